mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master_if.sv | 31 +++
 rtl/mem_master.sv | 139 +++++++++++++
 tb/tb_mem_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - requester, response and RAM-port bundle for mem_master
interface mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_mode;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [3:0]  ram_mode;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [7:0]  err_cnt;

   // mem_master side: owns the request acceptance, the response and the RAM port
   modport master (
      input  req_valid, req_mode, req_addr, req_wdata, resp_ready, ram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             ram_mode, ram_addr, ram_wdata, err_cnt
   );

   // environment side: requester plus the RAM
   modport slave (
      output req_valid, req_mode, req_addr, req_wdata, resp_ready, ram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             ram_mode, ram_addr, ram_wdata, err_cnt
   );
endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-outstanding load/store master in front of a combinational RAM port
module mem_master #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_master_if.master bus
);
   localparam logic [3:0] IO_NOP = 4'd0;
   localparam logic [3:0] IO_LB  = 4'd1;
   localparam logic [3:0] IO_LBU = 4'd2;
   localparam logic [3:0] IO_LH  = 4'd3;
   localparam logic [3:0] IO_LHU = 4'd4;
   localparam logic [3:0] IO_LW  = 4'd5;
   localparam logic [3:0] IO_SB  = 4'd6;
   localparam logic [3:0] IO_SH  = 4'd7;
   localparam logic [3:0] IO_SW  = 4'd8;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  ram_mode_q, ram_mode_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;

   logic is_load, is_store, is_legal, need_half, need_word, misaligned;

   // classify the presented request: load/store/nop, legality and alignment
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_legal  = 1'b1;
      need_half = 1'b0;
      need_word = 1'b0;
      case (bus.req_mode)
         IO_NOP:        ;
         IO_LB, IO_LBU: is_load = 1'b1;
         IO_LH, IO_LHU: begin is_load = 1'b1; need_half = 1'b1; end
         IO_LW:         begin is_load = 1'b1; need_word = 1'b1; end
         IO_SB:         is_store = 1'b1;
         IO_SH:         begin is_store = 1'b1; need_half = 1'b1; end
         IO_SW:         begin is_store = 1'b1; need_word = 1'b1; end
         default:       is_legal = 1'b0;
      endcase
      misaligned = (need_half && bus.req_addr[0]) ||
                   (need_word && (bus.req_addr[1:0] != 2'b00));
   end

   // next-state logic; ram_mode falls back to NOP whenever leaving READ/WRITE
   always_comb begin
      state_d      = state_q;
      ram_mode_d   = ram_mode_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      err_cnt_d    = err_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               resp_rdata_d = 32'h0;
               resp_err_d   = 1'b0;
               wait_cnt_d   = 4'd0;
               if (!is_legal || misaligned) begin
                  resp_err_d = 1'b1;
                  state_d    = S_RESP;
                  if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               end else if (is_load) begin
                  ram_mode_d = bus.req_mode;
                  ram_addr_d = bus.req_addr;
                  state_d    = S_READ;
               end else if (is_store) begin
                  ram_mode_d  = bus.req_mode;
                  ram_addr_d  = bus.req_addr;
                  ram_wdata_d = bus.req_wdata;
                  state_d     = S_WRITE;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_READ: begin
            if (wait_cnt_q == WAIT_LAST) begin
               resp_rdata_d = bus.ram_rdata;
               ram_mode_d   = IO_NOP;
               state_d      = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         S_WRITE: begin
            ram_mode_d = IO_NOP;
            state_d    = S_RESP;
         end
         default: begin
            if (bus.resp_ready) state_d = S_IDLE;
         end
      endcase
   end

   // state and output registers; reset also kills any in-flight RAM access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ram_mode_q   <= IO_NOP;
         ram_addr_q   <= 32'h0;
         ram_wdata_q  <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         err_cnt_q    <= 8'h0;
         wait_cnt_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         ram_mode_q   <= ram_mode_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         err_cnt_q    <= err_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.ram_mode   = ram_mode_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed self-checking bench for mem_master
module tb_mem_master;
   localparam logic [3:0] IO_NOP = 4'd0;
   localparam logic [3:0] IO_LB  = 4'd1;
   localparam logic [3:0] IO_LBU = 4'd2;
   localparam logic [3:0] IO_LH  = 4'd3;
   localparam logic [3:0] IO_LHU = 4'd4;
   localparam logic [3:0] IO_LW  = 4'd5;
   localparam logic [3:0] IO_SB  = 4'd6;
   localparam logic [3:0] IO_SH  = 4'd7;
   localparam logic [3:0] IO_SW  = 4'd8;

   logic clk;
   logic rst_n;
   logic preload;
   int   n_checks;
   int   n_errors;

   logic [7:0] mem [0:255];

   mem_master_if bus ();

   mem_master #(.WAIT_CYCLES(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational RAM read with sign/zero extension done by the RAM
   always_comb begin
      logic [7:0] a;
      a = bus.ram_addr[7:0];
      bus.ram_rdata = 32'h0;
      case (bus.ram_mode)
         IO_LB:  bus.ram_rdata = {{24{mem[a][7]}}, mem[a]};
         IO_LBU: bus.ram_rdata = {24'h0, mem[a]};
         IO_LH:  bus.ram_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
         IO_LHU: bus.ram_rdata = {16'h0, mem[a+8'd1], mem[a]};
         IO_LW:  bus.ram_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
         default: ;
      endcase
   end

   // RAM write port plus one-time preload of word 0x80 = 0x11223344
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h80] <= 8'h44;
         mem[8'h81] <= 8'h33;
         mem[8'h82] <= 8'h22;
         mem[8'h83] <= 8'h11;
      end else begin
         case (bus.ram_mode)
            IO_SB: mem[bus.ram_addr[7:0]] <= bus.ram_wdata[7:0];
            IO_SH: begin
               mem[bus.ram_addr[7:0]]       <= bus.ram_wdata[7:0];
               mem[bus.ram_addr[7:0]+8'd1]  <= bus.ram_wdata[15:8];
            end
            IO_SW: begin
               mem[bus.ram_addr[7:0]]       <= bus.ram_wdata[7:0];
               mem[bus.ram_addr[7:0]+8'd1]  <= bus.ram_wdata[15:8];
               mem[bus.ram_addr[7:0]+8'd2]  <= bus.ram_wdata[23:16];
               mem[bus.ram_addr[7:0]+8'd3]  <= bus.ram_wdata[31:24];
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // present one request; returns edges from acceptance to resp_valid and cycles with ram_mode != NOP
   task automatic run_req(input logic [3:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int mcyc);
      @(negedge clk);
      check("req_ready_before", {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid = 1'b1;
      bus.req_mode  = mode;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat  = 0;
      mcyc = 0;
      while (!bus.resp_valid && lat < 50) begin
         if (bus.ram_mode != IO_NOP) mcyc++;
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) check("resp_timeout", lat, 32'h0);
   endtask

   // hold resp_ready low for 'hold' cycles checking stability, then complete the handshake
   task automatic take_resp(input int hold, input logic [31:0] exp_rdata, input logic exp_err);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", {31'h0, bus.resp_valid}, 32'h1);
         check("hold_rdata", bus.resp_rdata, exp_rdata);
         check("hold_err", {31'h0, bus.resp_err}, {31'h0, exp_err});
         check("hold_ready", {31'h0, bus.req_ready}, 32'h0);
         @(negedge clk);
      end
      check("resp_rdata", bus.resp_rdata, exp_rdata);
      check("resp_err", {31'h0, bus.resp_err}, {31'h0, exp_err});
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check("post_hs_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("post_hs_ready", {31'h0, bus.req_ready}, 32'h1);
   endtask

   // full access with checked latency and RAM-port activity
   task automatic access(input string tag, input logic [3:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat, input int exp_mcyc,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int lat, mcyc;
      run_req(mode, addr, wdata, lat, mcyc);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_mcyc"}, mcyc, exp_mcyc);
      take_resp(0, exp_rdata, exp_err);
   endtask

   initial begin
      int lat, mcyc;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      preload = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_mode   = IO_NOP;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_ram_mode", {28'h0, bus.ram_mode}, 32'h0);
      check("rst_ram_addr", bus.ram_addr, 32'h0);
      check("rst_ram_wdata", bus.ram_wdata, 32'h0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_err", {31'h0, bus.resp_err}, 32'h0);
      check("rst_err_cnt", {24'h0, bus.err_cnt}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'h0, bus.req_ready}, 32'h1);
      // idle with req_valid low changes nothing
      @(negedge clk);
      check("idle_mode", {28'h0, bus.ram_mode}, 32'h0);
      check("idle_valid", {31'h0, bus.resp_valid}, 32'h0);

      access("lw80", IO_LW, 32'h80, 32'h0, 2, 2, 32'h11223344, 1'b0);
      check("ram_addr_hold", bus.ram_addr, 32'h80);
      access("sb81", IO_SB, 32'h81, 32'hAB, 1, 1, 32'h0, 1'b0);
      check("ram_wdata_hold", bus.ram_wdata, 32'hAB);
      access("lbu81", IO_LBU, 32'h81, 32'h0, 2, 2, 32'h000000AB, 1'b0);
      access("lb81", IO_LB, 32'h81, 32'h0, 2, 2, 32'hFFFFFFAB, 1'b0);
      access("lh80", IO_LH, 32'h80, 32'h0, 2, 2, 32'hFFFFAB44, 1'b0);
      access("lb83", IO_LB, 32'h83, 32'h0, 2, 2, 32'h00000011, 1'b0);

      access("lw82", IO_LW, 32'h82, 32'h0, 0, 0, 32'h0, 1'b1);
      access("sh83", IO_SH, 32'h83, 32'h1234, 0, 0, 32'h0, 1'b1);
      check("err_cnt_2", {24'h0, bus.err_cnt}, 32'd2);
      access("undef", 4'hC, 32'h80, 32'h0, 0, 0, 32'h0, 1'b1);
      access("nop", IO_NOP, 32'h81, 32'h0, 0, 0, 32'h0, 1'b0);
      check("err_cnt_3", {24'h0, bus.err_cnt}, 32'd3);

      access("sw84", IO_SW, 32'h84, 32'hDEADBEEF, 1, 1, 32'h0, 1'b0);
      access("lhu86", IO_LHU, 32'h86, 32'h0, 2, 2, 32'h0000DEAD, 1'b0);

      // slow consumer: response held stable for 5 cycles, next request right after handshake
      run_req(IO_LW, 32'h84, 32'h0, lat, mcyc);
      check("slow_lat", lat, 32'd2);
      take_resp(5, 32'hDEADBEEF, 1'b0);
      access("after_slow", IO_LBU, 32'h84, 32'h0, 2, 2, 32'h000000EF, 1'b0);

      // reset during READ aborts the access
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_mode  = IO_LW;
      bus.req_addr  = 32'h80;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("mid_read_mode", {28'h0, bus.ram_mode}, {28'h0, IO_LW});
      #2 rst_n = 1'b0;
      #1;
      check("abort_mode", {28'h0, bus.ram_mode}, 32'h0);
      check("abort_err_cnt", {24'h0, bus.err_cnt}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_valid", {31'h0, bus.resp_valid}, 32'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_valid_rel", {31'h0, bus.resp_valid}, 32'h0);
      access("lw_after_rst", IO_LW, 32'h80, 32'h0, 2, 2, 32'h1122AB44, 1'b0);

      // error counter saturation
      for (int i = 0; i < 255; i++) begin
         run_req(IO_LH, 32'h81, 32'h0, lat, mcyc);
         take_resp(0, 32'h0, 1'b1);
      end
      check("err_cnt_255", {24'h0, bus.err_cnt}, 32'd255);
      access("err256", IO_SW, 32'h86, 32'h0, 0, 0, 32'h0, 1'b1);
      check("err_cnt_sat", {24'h0, bus.err_cnt}, 32'd255);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
